// File: rtl/axis_window_crop.sv
// axis_window_crop: AXI4-Stream video crop.
// Tracks the (row, col) position of every accepted input pixel, latches the
// crop window on each start-of-frame pixel and forwards only the pixels that
// fall inside that window through a single registered output stage. The
// forwarded pixels form a well-formed smaller frame: tuser marks the first
// window pixel and tlast marks the end of each window row.
module axis_window_crop #(
  parameter int C_PIXEL_WIDTH = 8,
  parameter int C_IMG_WBITS   = 12,
  parameter int C_IMG_HBITS   = 12
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic [C_IMG_WBITS-1:0]   win_left,
  input  logic [C_IMG_HBITS-1:0]   win_top,
  input  logic [C_IMG_WBITS-1:0]   win_width,
  input  logic [C_IMG_HBITS-1:0]   win_height,
  input  logic                     s_axis_tvalid,
  output logic                     s_axis_tready,
  input  logic [C_PIXEL_WIDTH-1:0] s_axis_tdata,
  input  logic                     s_axis_tuser,
  input  logic                     s_axis_tlast,
  output logic                     m_axis_tvalid,
  input  logic                     m_axis_tready,
  output logic [C_PIXEL_WIDTH-1:0] m_axis_tdata,
  output logic                     m_axis_tuser,
  output logic                     m_axis_tlast
);

  localparam logic [C_IMG_WBITS-1:0]   ZERO_W = {C_IMG_WBITS{1'b0}};
  localparam logic [C_IMG_HBITS-1:0]   ZERO_H = {C_IMG_HBITS{1'b0}};
  localparam logic [C_IMG_WBITS-1:0]   ONE_W  = {{(C_IMG_WBITS-1){1'b0}}, 1'b1};
  localparam logic [C_IMG_HBITS-1:0]   ONE_H  = {{(C_IMG_HBITS-1){1'b0}}, 1'b1};
  localparam logic [C_PIXEL_WIDTH-1:0] ZERO_P = {C_PIXEL_WIDTH{1'b0}};

  // Position of the next pixel to arrive (valid only while a frame is active).
  logic [C_IMG_WBITS-1:0]   col_r;
  logic [C_IMG_HBITS-1:0]   row_r;
  logic                     frame_active_r;

  // Window captured on the last start-of-frame pixel.
  logic [C_IMG_WBITS-1:0]   lat_left_r;
  logic [C_IMG_WBITS-1:0]   lat_width_r;
  logic [C_IMG_HBITS-1:0]   lat_top_r;
  logic [C_IMG_HBITS-1:0]   lat_height_r;

  // Output register stage.
  logic                     m_valid_r;
  logic                     m_user_r;
  logic                     m_last_r;
  logic [C_PIXEL_WIDTH-1:0] m_data_r;

  // Per-pixel decode of the pixel currently on the input bus.
  logic                     ready_s;
  logic                     accept_s;
  logic                     active_s;
  logic [C_IMG_WBITS-1:0]   cur_col_s;
  logic [C_IMG_HBITS-1:0]   cur_row_s;
  logic [C_IMG_WBITS-1:0]   eff_left_s;
  logic [C_IMG_WBITS-1:0]   eff_width_s;
  logic [C_IMG_HBITS-1:0]   eff_top_s;
  logic [C_IMG_HBITS-1:0]   eff_height_s;
  logic [C_IMG_WBITS:0]     col_end_s;
  logic [C_IMG_HBITS:0]     row_end_s;
  logic                     row_hit_s;
  logic                     col_hit_s;
  logic                     sel_s;
  logic                     first_s;
  logic                     last_s;

  // The input may move whenever the output register is empty or draining;
  // dropped pixels follow the same rule so ordering stays simple.
  assign ready_s       = ~m_valid_r | m_axis_tready;
  assign accept_s      = s_axis_tvalid & ready_s;
  assign s_axis_tready = ready_s;

  assign m_axis_tvalid = m_valid_r;
  assign m_axis_tuser  = m_user_r;
  assign m_axis_tlast  = m_last_r;
  assign m_axis_tdata  = m_data_r;

  // Decode the current pixel's position and test it against the window.
  always_comb begin
    // A start-of-frame pixel is (0,0) and is judged against the live window,
    // since that is the value being latched on this very pixel.
    if (s_axis_tuser) begin
      cur_col_s    = ZERO_W;
      cur_row_s    = ZERO_H;
      eff_left_s   = win_left;
      eff_width_s  = win_width;
      eff_top_s    = win_top;
      eff_height_s = win_height;
      active_s     = 1'b1;
    end else begin
      cur_col_s    = col_r;
      cur_row_s    = row_r;
      eff_left_s   = lat_left_r;
      eff_width_s  = lat_width_r;
      eff_top_s    = lat_top_r;
      eff_height_s = lat_height_r;
      active_s     = frame_active_r;
    end
    // One extra bit so left+width and top+height never wrap.
    col_end_s = {1'b0, eff_left_s} + {1'b0, eff_width_s};
    row_end_s = {1'b0, eff_top_s} + {1'b0, eff_height_s};
    row_hit_s = (cur_row_s >= eff_top_s) && ({1'b0, cur_row_s} < row_end_s);
    col_hit_s = (cur_col_s >= eff_left_s) && ({1'b0, cur_col_s} < col_end_s);
    sel_s     = active_s & row_hit_s & col_hit_s;
    first_s   = (cur_row_s == eff_top_s) && (cur_col_s == eff_left_s);
    // A short input row closes the window row early on its own last pixel.
    last_s    = s_axis_tlast | (({1'b0, cur_col_s} + {1'b0, ONE_W}) == col_end_s);
  end

  // Advance the row/column position on every accepted input pixel.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      col_r <= ZERO_W;
      row_r <= ZERO_H;
    end else if (accept_s) begin
      if (s_axis_tlast) begin
        col_r <= ZERO_W;
        row_r <= cur_row_s + ONE_H;
      end else begin
        col_r <= cur_col_s + ONE_W;
        row_r <= cur_row_s;
      end
    end
  end

  // Capture the window on each accepted start-of-frame pixel.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      frame_active_r <= 1'b0;
      lat_left_r     <= ZERO_W;
      lat_width_r    <= ZERO_W;
      lat_top_r      <= ZERO_H;
      lat_height_r   <= ZERO_H;
    end else if (accept_s && s_axis_tuser) begin
      frame_active_r <= 1'b1;
      lat_left_r     <= win_left;
      lat_width_r    <= win_width;
      lat_top_r      <= win_top;
      lat_height_r   <= win_height;
    end
  end

  // Output register: load selected pixels, empty on a transfer, hold on a stall.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_valid_r <= 1'b0;
      m_user_r  <= 1'b0;
      m_last_r  <= 1'b0;
      m_data_r  <= ZERO_P;
    end else if (accept_s && sel_s) begin
      m_valid_r <= 1'b1;
      m_user_r  <= first_s;
      m_last_r  <= last_s;
      m_data_r  <= s_axis_tdata;
    end else if (m_axis_tready) begin
      m_valid_r <= 1'b0;
    end
  end

endmodule

// File: tb/tb_axis_window_crop.sv
// tb_axis_window_crop: directed and randomized checks of axis_window_crop.
// Frames are driven pixel by pixel; the expected cropped stream is computed
// from the window rules with plain loops over the frame and compared beat by
// beat with what the output handshake delivers.
module tb_axis_window_crop;

  localparam int PW = 8;
  localparam int WB = 12;
  localparam int HB = 12;

  logic          clk = 1'b0;
  logic          resetn = 1'b1;
  logic [WB-1:0] win_left, win_width;
  logic [HB-1:0] win_top, win_height;
  logic          s_tvalid, s_tready, s_tuser, s_tlast;
  logic [PW-1:0] s_tdata;
  logic          m_tvalid, m_tready, m_tuser, m_tlast;
  logic [PW-1:0] m_tdata;

  int n_assert = 0;
  int n_fail   = 0;
  int vprob    = 100;  // percent chance input is valid in a cycle
  int rprob    = 100;  // percent chance output is ready in a cycle
  int acc_cnt  = 0;

  logic [9:0] exp_q[$];
  logic [9:0] got_q[$];
  logic [7:0] fdata[0:255];

  logic       pv_stall = 1'b0;
  logic [9:0] pv_beat  = 10'd0;

  axis_window_crop #(
    .C_PIXEL_WIDTH(PW), .C_IMG_WBITS(WB), .C_IMG_HBITS(HB)
  ) dut (
    .clk(clk), .resetn(resetn),
    .win_left(win_left), .win_top(win_top),
    .win_width(win_width), .win_height(win_height),
    .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready),
    .s_axis_tdata(s_tdata), .s_axis_tuser(s_tuser), .s_axis_tlast(s_tlast),
    .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
    .m_axis_tdata(m_tdata), .m_axis_tuser(m_tuser), .m_axis_tlast(m_tlast)
  );

  always #5 clk = ~clk;

  // Downstream readiness, randomized per cycle from rprob.
  initial begin
    m_tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      m_tready = ($urandom_range(99) < rprob);
    end
  end

  // Output monitor: record transfers and require stability while stalled.
  always @(negedge clk) begin
    if (resetn) begin
      if (pv_stall) begin
        n_assert++;
        assert (m_tvalid === 1'b1 && {m_tuser, m_tlast, m_tdata} === pv_beat)
        else begin
          n_fail++;
          $error("FAIL stall_hold got v=%b beat=%h exp v=1 beat=%h",
                 m_tvalid, {m_tuser, m_tlast, m_tdata}, pv_beat);
        end
      end
      if (m_tvalid === 1'b1 && m_tready === 1'b1) got_q.push_back({m_tuser, m_tlast, m_tdata});
      pv_stall = (m_tvalid === 1'b1) && (m_tready !== 1'b1);
      pv_beat  = {m_tuser, m_tlast, m_tdata};
    end else begin
      pv_stall = 1'b0;
    end
  end

  task automatic send_pix(input logic [7:0] d, input logic u, input logic l);
    int guard = 0;
    while ($urandom_range(99) >= vprob) begin
      s_tvalid = 1'b0;
      @(posedge clk);
      #1;
    end
    s_tvalid = 1'b1;
    s_tdata  = d;
    s_tuser  = u;
    s_tlast  = l;
    @(negedge clk);
    while (s_tready !== 1'b1 && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 1000) begin
      n_assert++;
      n_fail++;
      $error("FAIL input_handshake got tready=%b exp 1 within 1000 cycles", s_tready);
    end
    @(posedge clk);
    #1;
    acc_cnt++;
  endtask

  task automatic fill_pattern(input int fw, input int fh);
    for (int r = 0; r < fh; r++)
      for (int c = 0; c < fw; c++) fdata[r*fw+c] = 8'((r * 16 + c) & 255);
  endtask

  task automatic fill_random(input int fw, input int fh);
    for (int i = 0; i < fw * fh; i++) fdata[i] = 8'($urandom_range(255));
  endtask

  // Reference: walk the frame in raster order and keep what lies in the window.
  task automatic model_frame(input int fw, input int fh, input int l, input int t,
                             input int w, input int h);
    int re;
    re = (l + w < fw) ? l + w : fw;
    for (int r = 0; r < fh; r++)
      for (int c = 0; c < fw; c++)
        if (r >= t && r < t + h && c >= l && c < l + w)
          exp_q.push_back({(r == t && c == l), (c == re - 1), fdata[r*fw+c]});
  endtask

  task automatic send_frame(input int fw, input int fh, input int l, input int t,
                            input int w, input int h, input int chg_at,
                            input int nl, input int nt, input int nw, input int nh);
    int idx = 0;
    win_left = WB'(l); win_top = HB'(t); win_width = WB'(w); win_height = HB'(h);
    for (int r = 0; r < fh; r++)
      for (int c = 0; c < fw; c++) begin
        send_pix(fdata[r*fw+c], (r == 0 && c == 0), (c == fw - 1));
        idx++;
        if (idx == chg_at) begin
          win_left = WB'(nl); win_top = HB'(nt); win_width = WB'(nw); win_height = HB'(nh);
        end
      end
    s_tvalid = 1'b0;
    s_tuser  = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic check_out(input string tag);
    int guard = 0;
    int n;
    while (got_q.size() < exp_q.size() && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    repeat (10) @(negedge clk);
    n_assert++;
    assert (got_q.size() === exp_q.size())
    else begin
      n_fail++;
      $error("FAIL %s_count got %0d exp %0d", tag, got_q.size(), exp_q.size());
    end
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      n_assert++;
      assert (got_q[i] === exp_q[i])
      else begin
        n_fail++;
        $error("FAIL %s[%0d] got u/l/data=%h exp %h", tag, i, got_q[i], exp_q[i]);
      end
    end
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    int fw, fh, l, t, w, h;
    time t0;
    s_tvalid = 1'b0; s_tuser = 1'b0; s_tlast = 1'b0; s_tdata = 8'd0;
    win_left = 12'd0; win_top = 12'd0; win_width = 12'd0; win_height = 12'd0;

    // Reset values.
    #3 resetn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_assert++;
    assert ({m_tvalid, m_tuser, m_tlast, m_tdata} === 11'd0)
    else begin
      n_fail++;
      $error("FAIL reset_outputs got %h exp 000", {m_tvalid, m_tuser, m_tlast, m_tdata});
    end
    resetn = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n_assert++;
    assert (s_tready === 1'b1)
    else begin
      n_fail++;
      $error("FAIL reset_tready got %b exp 1", s_tready);
    end
    @(posedge clk);
    #1;

    // Basic crop, continuous flow.
    fill_pattern(8, 8);
    model_frame(8, 8, 3, 3, 5, 3);
    send_frame(8, 8, 3, 3, 5, 3, -1, 0, 0, 0, 0);
    check_out("basic");

    // Same crop under random valid/ready.
    vprob = 60; rprob = 50;
    model_frame(8, 8, 3, 3, 5, 3);
    send_frame(8, 8, 3, 3, 5, 3, -1, 0, 0, 0, 0);
    check_out("backpressure");
    vprob = 100; rprob = 100;
    repeat (2) @(posedge clk);
    #1;

    // Zero width, then zero height: full-rate drain, no output.
    for (int k = 0; k < 2; k++) begin
      acc_cnt = 0;
      t0 = $time;
      if (k == 0) send_frame(8, 8, 1, 1, 0, 4, -1, 0, 0, 0, 0);
      else        send_frame(8, 8, 1, 1, 4, 0, -1, 0, 0, 0, 0);
      n_assert++;
      assert (acc_cnt === 64 && int'(($time - t0) / 10) === 64)
      else begin
        n_fail++;
        $error("FAIL zero_drain got beats=%0d cycles=%0d exp 64/64", acc_cnt, int'(($time - t0) / 10));
      end
      check_out("zero_window");
    end

    // Clipping against the frame edges.
    model_frame(8, 8, 6, 6, 5, 5);
    send_frame(8, 8, 6, 6, 5, 5, -1, 0, 0, 0, 0);
    check_out("clip");

    // Window change mid-frame takes effect on the next frame only.
    model_frame(8, 8, 1, 2, 4, 3);
    send_frame(8, 8, 1, 2, 4, 3, 20, 4, 0, 3, 2);
    model_frame(8, 8, 4, 0, 3, 2);
    send_frame(8, 8, 4, 0, 3, 2, -1, 0, 0, 0, 0);
    check_out("win_change");

    // Random frame sizes, windows, data and flow control.
    vprob = 70; rprob = 60;
    for (int k = 0; k < 4; k++) begin
      fw = $urandom_range(12, 4); fh = $urandom_range(10, 3);
      l = $urandom_range(fw, 0);  w = $urandom_range(fw + 2, 0);
      t = $urandom_range(fh, 0);  h = $urandom_range(fh + 2, 0);
      fill_random(fw, fh);
      model_frame(fw, fh, l, t, w, h);
      send_frame(fw, fh, l, t, w, h, -1, 0, 0, 0, 0);
      check_out("random");
    end
    vprob = 100; rprob = 0;
    repeat (3) @(posedge clk);
    #1;

    // Reset while an output pixel is stalled.
    fill_pattern(8, 8);
    win_left = 12'd0; win_top = 12'd0; win_width = 12'd8; win_height = 12'd8;
    send_pix(fdata[0], 1'b1, 1'b0);
    s_tvalid = 1'b0;
    s_tuser  = 1'b0;
    @(negedge clk);
    n_assert++;
    assert (m_tvalid === 1'b1 && m_tdata === 8'h00)
    else begin
      n_fail++;
      $error("FAIL pre_reset_stall got v=%b d=%h exp v=1 d=00", m_tvalid, m_tdata);
    end
    #2 resetn = 1'b0;
    #1;
    n_assert++;
    assert ({m_tvalid, m_tuser, m_tlast} === 3'b000)
    else begin
      n_fail++;
      $error("FAIL reset_flush got v/u/l=%b exp 000", {m_tvalid, m_tuser, m_tlast});
    end
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
    rprob = 100;
    got_q.delete();
    @(posedge clk);
    #1;
    for (int i = 0; i < 12; i++) send_pix(8'(i + 8), 1'b0, (i % 8 == 7));
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    check_out("pre_sof_drop");
    model_frame(8, 8, 2, 1, 3, 2);
    send_frame(8, 8, 2, 1, 3, 2, -1, 0, 0, 0, 0);
    check_out("post_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  // Global bound so the run always ends.
  initial begin
    #2000000;
    $display("FAIL global_timeout got no completion exp completion within 2 ms");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/axis_window_crop.md
# axis_window_crop

AXI4-Stream video crop block: passes through only the pixels inside a rectangular window of each input frame and discards all others. The output is a well-formed smaller frame: `tuser` marks the first window pixel and `tlast` marks each window row end. The block sits between a video source (sensor/DMA) and downstream processing.

## Interface

Module name: `axis_window_crop`.

Parameters:
- `C_PIXEL_WIDTH`, default 8: tdata width in bits.
- `C_IMG_WBITS`, default 12: width of column counters and of `win_left`/`win_width`.
- `C_IMG_HBITS`, default 12: width of row counters and of `win_top`/`win_height`.

Clocking and reset: one clock; reset is asynchronous and active-low.

Ports:
- `clk` in 1: clock; all logic on the rising edge.
- `resetn` in 1: asynchronous active-low reset.
- `win_left` in C_IMG_WBITS: first window column (0-based).
- `win_top` in C_IMG_HBITS: first window row (0-based).
- `win_width` in C_IMG_WBITS: window width in pixels; 0 disables output.
- `win_height` in C_IMG_HBITS: window height in rows; 0 disables output.
- `s_axis_tvalid` in 1, `s_axis_tready` out 1: input handshake.
- `s_axis_tdata` in C_PIXEL_WIDTH: input pixel.
- `s_axis_tuser` in 1: start of frame (first pixel).
- `s_axis_tlast` in 1: last pixel of an input row.
- `m_axis_tvalid` out 1, `m_axis_tready` in 1: output handshake.
- `m_axis_tdata` out C_PIXEL_WIDTH: output pixel.
- `m_axis_tuser` out 1: first pixel of the cropped frame.
- `m_axis_tlast` out 1: last pixel of a cropped row.

## Operation

Input position tracking:
- An input pixel is counted only when it transfers (`s_axis_tvalid & s_axis_tready`).
- A pixel with `tuser` is row 0, column 0, and starts a new frame.
- A pixel with `tlast` makes the next pixel column 0 of row+1.
- Otherwise the column increments.

Window capture:
- On each accepted `tuser` pixel, `win_*` are latched into internal registers and held for the whole frame.
- Changes to `win_*` mid-frame have no effect until the next `tuser`.

Selection:
- A pixel is forwarded if and only if `win_top <= row < win_top+win_height` and `win_left <= col < win_left+win_width` (latched values).
- Comparisons are done in width+1 bits, so `left+width` does not wrap.
- All other pixels are accepted and dropped.

Output sideband:
- `m_axis_tuser` = 1 on the pixel at (win_top, win_left).
- `m_axis_tlast` = 1 on the pixel at column win_left+win_width-1.
- If an input row ends (`s_axis_tlast`) inside the window before that column, `m_axis_tlast` is asserted on that input-last pixel instead.

Boundary cases:
- Window extending beyond the image emits only the existing pixels; no padding.
- `win_width`==0 or `win_height`==0: no output for that frame; input still drains at full rate.
- After reset, input is accepted and dropped until the first `tuser` pixel.
- A `tuser` arriving mid-frame restarts counting immediately (new frame, new window latch).

## Timing

- Output is a single register stage. `m_axis_*` are registered; latency is 1 cycle from input accept to `m_axis_tvalid`.
- `s_axis_tready` = `~m_axis_tvalid | m_axis_tready`. Dropped pixels obey the same rule.
- Output register update:
  - Loaded when an input is accepted and selected.
  - `m_axis_tvalid` clears on an output transfer with no new selected input.
  - Back-to-back streaming at 1 pixel/cycle when `m_axis_tready` stays high.
- AXI rules:
  - `m_axis_tdata/tuser/tlast` are held stable while `m_axis_tvalid & ~m_axis_tready`.
  - `m_axis_tvalid` never drops without a transfer.
- Reset values:
  - `m_axis_tvalid`=0, `m_axis_tuser`=0, `m_axis_tlast`=0, `m_axis_tdata`=0.
  - Row/col counters = 0; latched window = 0; state "awaiting frame start".
  - `s_axis_tready` = 1 one cycle after reset release.
- Reset mid-frame discards any held output pixel.

## Test plan

- **Basic crop:** 8x8 frame, data=row*16+col, window left=3 top=3 width=5 height=3, continuous valid/ready. Output must be 33 34 35 36 37 / 43..47 / 53..57 with `tuser` on 0x33 and `tlast` on 0x37, 0x47 and 0x57, and 15 output beats total.
- **Random backpressure:** same frame with random `s_axis_tvalid` and `m_axis_tready`. Output must be the identical sequence, with no loss or duplication and data stable while stalled.
- **Zero window:** width=0 (then height=0) over two frames. There must be no `m_axis_tvalid`, and all 64 input beats per frame must be accepted.
- **Clipping:** 8x8 frame, left=6 top=6 width=5 height=5. Output must be 66 67 / 76 77 with `tlast` on 0x67 and 0x77 and `tuser` on 0x66.
- **Mid-frame window change:** change `win_*` during frame 1. Frame 1 must use the old window; frame 2 must use the new window from its `tuser` pixel.
- **Reset mid-stream:** assert `resetn`=0 while output is stalled. `m_axis_tvalid` must be 0 immediately, and after release, pixels before the next `tuser` must be dropped.
